// File: rtl/interlock_pkg.sv
// Shared types and helpers for the break-before-make output interlock.
package interlock_pkg;

  localparam int unsigned RESTART_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StBreak,
    StSettle,
    StMake,
    StEstop
  } state_e;

  // Number of unordered phase pairs for n phases.
  function automatic int unsigned n_pair(input int unsigned n);
    return n * (n - 1) / 2;
  endfunction

  // 1-based pair index for phases i<j: (1,2)=1, (1,3)=2, (2,3)=3, (1,4)=4, ...
  function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j);
    return (j - 1) * (j - 2) / 2 + i;
  endfunction

endpackage

// File: rtl/interlock_pair_mask.sv
// Masks pair switches whose two endpoint phases are both requested.
module interlock_pair_mask
  import interlock_pkg::*;
#(
  parameter int unsigned N_PHASE = 8,
  localparam int unsigned N_PAIR = n_pair(N_PHASE)
) (
  input  logic [1:N_PHASE] outP,
  input  logic [1:N_PAIR]  out,
  output logic [1:N_PAIR]  out_masked,
  output logic             conflict_any
);

  // Walk every pair (i,j), drop it if both endpoints are live and flag the drop.
  always_comb begin
    out_masked   = '0;
    conflict_any = 1'b0;
    for (int unsigned j = 2; j <= N_PHASE; j++) begin
      for (int unsigned i = 1; i < j; i++) begin
        out_masked[pair_idx(i, j)] = out[pair_idx(i, j)] & ~(outP[i] & outP[j]);
        conflict_any = conflict_any | (out[pair_idx(i, j)] & outP[i] & outP[j]);
      end
    end
  end

endmodule

// File: rtl/interlock_out_ctrl.sv
// Break / settle / make interlock between the command decoder and the output drivers.
module interlock_out_ctrl
  import interlock_pkg::*;
#(
  parameter int unsigned N_PHASE       = 8,
  parameter int unsigned SETTLE_CYCLES = 500000,
  localparam int unsigned N_PAIR = n_pair(N_PHASE),
  localparam int unsigned CNT_W  = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic                 pclk_50M,
  input  logic                 rst,
  input  logic [1:N_PHASE]     outP,
  input  logic [1:N_PAIR]      out,
  input  logic                 estop,
  input  logic                 clr,
  output logic [1:N_PHASE]     eoutP,
  output logic [1:N_PAIR]      eout,
  output logic                 busy,
  output logic                 conflict,
  output logic [RESTART_W-1:0] restart_cnt
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [1:N_PHASE]       outP_q;
  logic [1:N_PAIR]        out_q;
  logic [1:N_PHASE]       eoutP_q, eoutP_d;
  logic [1:N_PAIR]        eout_q, eout_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   conflict_q, conflict_d;
  logic [RESTART_W-1:0]   restart_q, restart_d;
  logic                   conflict_set, restart_inc;
  logic [1:N_PAIR]        out_masked;
  logic                   conflict_any;
  logic                   chg;

  interlock_pair_mask #(
    .N_PHASE (N_PHASE)
  ) u_pair_mask (
    .outP         (outP),
    .out          (out),
    .out_masked   (out_masked),
    .conflict_any (conflict_any)
  );

  assign chg = (outP != outP_q) | (out != out_q);

  // State register.
  always_ff @(posedge pclk_50M) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; estop overrides every state.
  always_comb begin
    state_d = state_q;
    if (estop) begin
      state_d = StEstop;
    end else begin
      unique case (state_q)
        StIdle:   if (chg) state_d = StBreak;
        StBreak:  state_d = StSettle;
        StSettle: begin
          if (chg)                  state_d = StBreak;
          else if (cnt_q == CntLast) state_d = StMake;
        end
        StMake:   state_d = StIdle;
        StEstop:  state_d = StBreak;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Output/datapath next values: phases only fall in break/estop and only rise in make.
  always_comb begin
    eoutP_d      = eoutP_q;
    eout_d       = eout_q;
    cnt_d        = cnt_q;
    conflict_set = 1'b0;
    restart_inc  = 1'b0;
    if (estop || state_q == StEstop) begin
      eoutP_d = '0;
      eout_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StBreak: begin
          eoutP_d      = eoutP_q & outP;
          eout_d       = (outP == '0) ? '0 : out_masked;
          cnt_d        = '0;
          conflict_set = conflict_any;
        end
        StSettle: begin
          if (chg)                   restart_inc = 1'b1;
          else if (cnt_q != CntLast) cnt_d = cnt_q + CNT_W'(1);
        end
        StMake:  eoutP_d = eoutP_q | outP;
        default: ;
      endcase
    end
    // Same-cycle set/increment takes precedence over clr.
    if (conflict_set) conflict_d = 1'b1;
    else if (clr)     conflict_d = 1'b0;
    else              conflict_d = conflict_q;
    if (restart_inc)  restart_d = (restart_q == '1) ? restart_q : restart_q + RESTART_W'(1);
    else if (clr)     restart_d = '0;
    else              restart_d = restart_q;
  end

  // Datapath registers and input copies for change detection.
  always_ff @(posedge pclk_50M) begin
    if (rst) begin
      outP_q     <= '0;
      out_q      <= '0;
      eoutP_q    <= '0;
      eout_q     <= '0;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
      restart_q  <= '0;
    end else begin
      outP_q     <= outP;
      out_q      <= out;
      eoutP_q    <= eoutP_d;
      eout_q     <= eout_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
      restart_q  <= restart_d;
    end
  end

  assign eoutP       = eoutP_q;
  assign eout        = eout_q;
  assign busy        = (state_q != StIdle);
  assign conflict    = conflict_q;
  assign restart_cnt = restart_q;

endmodule

// File: tb/tb_interlock_out_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_interlock_out_ctrl;

  localparam int unsigned NP = 8;
  localparam int unsigned NK = 28;
  localparam int unsigned ST = 16;

  logic          pclk_50M = 1'b0;
  logic          rst = 1'b1, estop = 1'b0, clr = 1'b0;
  logic [1:NP]   outP = '0;
  logic [1:NK]   out = '0;
  logic [1:NP]   eoutP;
  logic [1:NK]   eout;
  logic          busy, conflict;
  logic [7:0]    restart_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: pending break, settle countdown, pending make, stopped.
  logic [1:NP] m_ep = '0, m_pp = '0;
  logic [1:NK] m_eo = '0, m_po = '0;
  bit          m_conf = 0, m_brk = 0, m_mk = 0, m_stop = 0;
  int          m_rc = 0, m_left = 0;

  logic [1:NK] o_none, o_12, o_78, ro;
  logic [1:NP] rp;
  int          es_left;

  always #10 pclk_50M = ~pclk_50M;

  interlock_out_ctrl #(
    .N_PHASE       (NP),
    .SETTLE_CYCLES (ST)
  ) dut (
    .pclk_50M    (pclk_50M),
    .rst         (rst),
    .outP        (outP),
    .out         (out),
    .estop       (estop),
    .clr         (clr),
    .eoutP       (eoutP),
    .eout        (eout),
    .busy        (busy),
    .conflict    (conflict),
    .restart_cnt (restart_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit chg, inc, set, both;
    int k;
    chg = (outP != m_pp) || (out != m_po);
    inc = 0;
    set = 0;
    if (rst) begin
      m_ep = '0; m_eo = '0; m_conf = 0; m_rc = 0;
      m_brk = 0; m_mk = 0; m_stop = 0; m_left = 0;
      m_pp = '0; m_po = '0;
      return;
    end
    if (estop) begin
      m_ep = '0; m_eo = '0;
      m_brk = 0; m_mk = 0; m_left = 0; m_stop = 1;
    end else if (m_stop) begin
      m_ep = '0; m_eo = '0;
      m_stop = 0; m_brk = 1;
    end else if (m_brk) begin
      k = 0;
      m_ep = m_ep & outP;
      for (int j = 2; j <= NP; j++) begin
        for (int i = 1; i < j; i++) begin
          k++;
          both = outP[i] && outP[j];
          m_eo[k] = (outP != '0) && out[k] && !both;
          if (out[k] && both) set = 1;
        end
      end
      m_brk = 0;
      m_left = ST;
    end else if (m_left > 0) begin
      if (chg) begin
        inc = 1; m_left = 0; m_brk = 1;
      end else if (m_left == 1) begin
        m_left = 0; m_mk = 1;
      end else begin
        m_left--;
      end
    end else if (m_mk) begin
      m_ep = m_ep | outP;
      m_mk = 0;
    end else if (chg) begin
      m_brk = 1;
    end
    if (set)      m_conf = 1;
    else if (clr) m_conf = 0;
    if (inc)      m_rc = (m_rc < 255) ? m_rc + 1 : 255;
    else if (clr) m_rc = 0;
    m_pp = outP;
    m_po = out;
  endtask

  task automatic step(input logic [1:NP] p, input logic [1:NK] o, input logic es,
                      input logic cl, input logic r);
    bit bexp;
    outP = p; out = o; estop = es; clr = cl; rst = r;
    model_step();
    bexp = m_brk || m_mk || m_stop || (m_left > 0);
    @(posedge pclk_50M);
    @(negedge pclk_50M);
    chk("eoutP", 64'(eoutP), 64'(m_ep));
    chk("eout", 64'(eout), 64'(m_eo));
    chk("busy", 64'(busy), 64'(bexp));
    chk("conflict", 64'(conflict), 64'(m_conf));
    chk("restart_cnt", 64'(restart_cnt), 64'(m_rc));
  endtask

  task automatic run(input int n, input logic [1:NP] p, input logic [1:NK] o);
    for (int i = 0; i < n; i++) step(p, o, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    o_none = '0;
    o_12 = '0;  o_12[1] = 1'b1;
    o_78 = '0;  o_78[28] = 1'b1;

    // Reset state.
    step('0, o_none, 1'b0, 1'b0, 1'b1);
    step('0, o_none, 1'b0, 1'b0, 1'b1);
    chk("rst_eoutP", 64'(eoutP), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // 1: phases 1,2 with pair (1,2) requested -> masked, conflict, make at E19.
    run(2, 8'b1100_0000, o_12);
    chk("s1_eout1", 64'(eout[1]), 64'd0);
    chk("s1_conflict", 64'(conflict), 64'd1);
    run(16, 8'b1100_0000, o_12);
    chk("s1_eoutP_pre", 64'(eoutP), 64'd0);
    run(1, 8'b1100_0000, o_12);
    chk("s1_eoutP", 64'(eoutP), 64'hC0);
    run(1, 8'b1100_0000, o_12);
    chk("s1_busy", 64'(busy), 64'd0);

    // 2: move to phase 3; phases 1 and 3 must never be on together.
    for (int i = 1; i <= 19; i++) begin
      step(8'b0010_0000, o_none, 1'b0, 1'b0, 1'b0);
      chk("s2_overlap", 64'(eoutP[1] & eoutP[3]), 64'd0);
      if (i == 2) chk("s2_break", 64'(eoutP), 64'd0);
    end
    chk("s2_make", 64'(eoutP), 64'h20);

    // 3: change request inside settle -> one restart, make counted from second break.
    run(9, 8'b0001_0000, o_none);
    run(18, 8'b0001_1000, o_none);
    chk("s3_restart", 64'(restart_cnt), 64'd1);
    chk("s3_early", 64'(eoutP), 64'd0);
    run(1, 8'b0001_1000, o_none);
    chk("s3_make", 64'(eoutP), 64'h18);

    // 4: estop during settle, then release and full re-settle.
    ro = 28'($urandom);
    run(6, 8'b1000_0001, ro);
    step(8'b1000_0001, ro, 1'b1, 1'b0, 1'b0);
    chk("s4_eoutP", 64'(eoutP), 64'd0);
    chk("s4_eout", 64'(eout), 64'd0);
    for (int i = 0; i < 4; i++) step(8'b1000_0001, ro, 1'b1, 1'b0, 1'b0);
    run(19, 8'b1000_0001, ro);
    chk("s4_make", 64'(eoutP), 64'h81);

    // 5: reset mid-settle, held request restarts normally.
    run(6, 8'b0100_0100, o_none);
    step(8'b0100_0100, o_none, 1'b0, 1'b0, 1'b1);
    chk("s5_rst_busy", 64'(busy), 64'd0);
    run(19, 8'b0100_0100, o_none);
    chk("s5_make", 64'(eoutP), 64'h44);

    // 6: toggle through settle until restart_cnt saturates, then clr.
    for (int i = 0; i < 600; i++)
      step((i % 2 == 0) ? 8'b0000_0011 : 8'b0000_0010, o_78, 1'b0, 1'b0, 1'b0);
    chk("s6_sat", 64'(restart_cnt), 64'd255);
    step(8'b0000_0010, o_78, 1'b0, 1'b0, 1'b0);
    step(8'b0000_0010, o_78, 1'b0, 1'b1, 1'b0);
    chk("s6_clr_rc", 64'(restart_cnt), 64'd0);
    chk("s6_clr_conf", 64'(conflict), 64'd0);

    // Random traffic against the model.
    rp = '0;
    ro = '0;
    es_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        rp = 8'($urandom);
        ro = 28'($urandom);
      end
      if (es_left > 0) es_left--;
      else if ($urandom_range(0, 149) == 0) es_left = $urandom_range(1, 6);
      step(rp, ro, es_left > 0, $urandom_range(0, 29) == 0, $urandom_range(0, 499) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
